fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. Issues one 16-bit read at a time
//             and buffers the returned words, with their addresses, in a
//             small FIFO for the decoder. A redirect flushes the buffer and
//             restarts fetch at a new address. If a read is still in flight
//             when the redirect arrives, its data is dropped when it returns.
//
//  Ports    : clk          - sole clock, rising edge
//             reset        - synchronous, active-high reset
//             redirect     - flush buffer and restart fetch at redirect_pc
//             redirect_pc  - new fetch address (bit 0 ignored)
//             mem_address  - fetch address (the fetch PC register)
//             mem_read     - read request, held until mem_resp
//             mem_rdata    - read data, valid while mem_resp=1
//             mem_resp     - one-cycle read completion strobe
//             ir_valid     - buffer head is valid
//             ir_out       - head instruction word (0 when empty)
//             ir_pc        - head instruction address (0 when empty)
//             ir_ready     - consumer accepts the head
//
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_address,
    output logic        mem_read,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic        ir_valid,
    output logic [15:0] ir_out,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_AW = $clog2(DEPTH);

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_AW-1:0] c_LAST      = c_AW'(DEPTH - 1);
    localparam logic [15:0]     c_RESET_PC  = RESET_PC & 16'hFFFE;

    // IDLE : no read outstanding
    // FETCH: read outstanding, data will be kept
    // DROP : read outstanding, data will be discarded
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [15:0]     r_pc;
    logic [15:0]     r_pend_pc;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [15:0]     r_ir_q [DEPTH];
    logic [15:0]     r_pc_q [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic [15:0]     w_target;

    function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_AW'(1);
    endfunction

    // Masking keeps every bit of redirect_pc in the expression; bit 0 is
    // forced low because instructions are halfword aligned.
    assign w_target   = redirect_pc & 16'hFFFE;
    assign w_nonempty = (r_count != '0);
    // A push only ever happens from FETCH; a redirect turns the returning
    // word into a discard.
    assign w_push     = (r_state == c_FETCH) && mem_resp && !redirect;
    assign w_pop      = ir_valid && ir_ready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (redirect || (r_count < c_DEPTH_CNT)) begin
                    w_state_next = c_FETCH;
                end
            end
            c_FETCH: begin
                if (redirect) begin
                    w_state_next = mem_resp ? c_FETCH : c_DROP;
                end else if (mem_resp) begin
                    // Chain straight into the next read while room remains.
                    w_state_next = (w_count_next < c_DEPTH_CNT) ? c_FETCH : c_IDLE;
                end
            end
            c_DROP: begin
                if (mem_resp) begin
                    w_state_next = c_FETCH;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        mem_read    = (r_state != c_IDLE);
        mem_address = r_pc;
        ir_valid    = w_nonempty && !redirect;
        ir_out      = 16'h0000;
        ir_pc       = 16'h0000;
        if (w_nonempty) begin
            ir_out = r_ir_q[r_rd_ptr];
            ir_pc  = r_pc_q[r_rd_ptr];
        end
    end

    // ------------------------------------------------------------ fetch PC
    // While a read is outstanding the bus address must stay put, so a
    // redirect without a completing response parks its target in r_pend_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= c_RESET_PC;
            r_pend_pc <= c_RESET_PC;
        end else if (redirect) begin
            if ((r_state == c_IDLE) || mem_resp) begin
                r_pc <= w_target;
            end else begin
                r_pend_pc <= w_target;
            end
        end else if (w_push) begin
            r_pc <= r_pc + 16'd2;
        end else if ((r_state == c_DROP) && mem_resp) begin
            r_pc <= r_pend_pc;
        end
    end

    // ------------------------------------------------------- buffer control
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
        end
    end

    // Storage needs no reset: the head is only shown when r_count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ir_q[r_wr_ptr] <= mem_rdata;
            r_pc_q[r_wr_ptr] <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed, table-driven bench for fetch_unit. Each record holds
//             one cycle of inputs and the outputs expected in that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        ir_valid;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int n_pass;
    int n_total;

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        rdy;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl [28];

    fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .ir_valid    (ir_valid),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rst, input logic rdr, input logic [15:0] rpc,
        input logic resp, input logic [15:0] rdata, input logic rdy,
        input logic e_rd, input logic [15:0] e_addr, input logic e_v,
        input logic [15:0] e_ir, input logic [15:0] e_pc);
        vec_t v;
        v.rst = rst;   v.rdr = rdr;       v.rpc = rpc;
        v.resp = resp; v.rdata = rdata;   v.rdy = rdy;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v;
        v.e_ir = e_ir; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input int idx, input string nm,
                       input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL step %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    // Called right after a falling edge: drive, let combinational paths
    // settle, compare, then move on to the next falling edge.
    task automatic apply(input vec_t v, input int idx);
        reset       = v.rst;
        redirect    = v.rdr;
        redirect_pc = v.rpc;
        mem_resp    = v.resp;
        mem_rdata   = v.rdata;
        ir_ready    = v.rdy;
        #1;
        chk(idx, "mem_read",    {15'd0, mem_read}, {15'd0, v.e_rd});
        chk(idx, "mem_address", mem_address,       v.e_addr);
        chk(idx, "ir_valid",    {15'd0, ir_valid}, {15'd0, v.e_v});
        chk(idx, "ir_out",      ir_out,            v.e_ir);
        chk(idx, "ir_pc",       ir_pc,             v.e_pc);
        @(negedge clk);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_rdata   = 16'h0000;
        mem_resp    = 1'b0;
        ir_ready    = 1'b0;

        //              rst   rdr   rpc       resp  rdata     rdy   | rd    addr      v     ir        pc
        // reset state, then two fetches answered one cycle after each read
        tbl[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0000);
        tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h1234, 16'h0000);
        // full: IDLE, then a single pop, then fetch at 0004 resumes
        tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h1234, 16'h0000);
        tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h1234, 16'h0000);
        tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h5678, 16'h0002);
        tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h5678, 16'h0002);
        // redirect to 3001 with read of 0004 pending; response 3 cycles later
        tbl[10] = mk(1'b0, 1'b1, 16'h3001, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h5678, 16'h0002);
        tbl[11] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        tbl[12] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        tbl[13] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        tbl[14] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 16'h0000);
        tbl[15] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 16'h0000);
        tbl[16] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3002, 1'b1, 16'hAAAA, 16'h3000);
        // redirect together with mem_resp: data discarded, count cleared
        tbl[17] = mk(1'b0, 1'b1, 16'h5000, 1'b1, 16'hBBBB, 1'b0, 1'b1, 16'h3002, 1'b0, 16'hAAAA, 16'h3000);
        tbl[18] = mk(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hCCCC, 1'b0, 1'b1, 16'h5000, 1'b0, 16'h0000, 16'h0000);
        // PC wrap FFFE -> 0000 -> 0002 with continuous ir_ready
        tbl[19] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000);
        tbl[20] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000);
        tbl[21] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h1111, 16'hFFFE);
        tbl[22] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h2222, 16'h0000);
        tbl[23] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h3333, 16'h0002);
        // reset while a read is outstanding and one entry is buffered
        tbl[24] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);
        tbl[25] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h4444, 16'h0004);
        tbl[26] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[27] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        repeat (2) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i], i);
        end

        // Second redirect while already in DROP: the later target wins.
        apply(mk(1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000), 100);
        apply(mk(1'b0, 1'b1, 16'h2001, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000), 101);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000), 102);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 16'h0000), 103);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888, 1'b0, 1'b1, 16'h2002, 1'b1, 16'h7777, 16'h2000), 104);

        // Full buffer in IDLE, then redirect with ir_ready high: no pop,
        // buffer flushed, fetch restarts at the target.
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2004, 1'b1, 16'h7777, 16'h2000), 200);
        apply(mk(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2004, 1'b0, 16'h7777, 16'h2000), 201);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000), 202);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000), 203);
        apply(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0102, 1'b1, 16'h9999, 16'h0100), 204);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
